// File: rtl/smoldvi_link_ctrl.sv
// Pixel-domain DVI link sequencer: debounces HPD, starts the clock pair before
// the data lanes, and drains to a frame boundary on shutdown.
module smoldvi_link_ctrl #(
    parameter int unsigned W_CTR        = 16,
    parameter int unsigned HPD_DEBOUNCE = 16
) (
    input  logic             clk_pix,
    input  logic             rst_n_pix,
    input  logic             en,
    input  logic             hpd,
    input  logic [W_CTR-1:0] warmup_cycles,
    input  logic             frame_end,
    output logic [9:0]       clk_pattern,
    output logic             lane_en,
    output logic             timing_rst_n,
    output logic             hpd_ok,
    output logic [1:0]       state,
    output logic             link_up
);

    typedef enum logic [1:0] {
        StOff     = 2'd0,
        StClkOnly = 2'd1,
        StRun     = 2'd2,
        StDrain   = 2'd3
    } state_e;

    localparam logic [9:0]  ClkPattern = 10'b11111_00000;
    localparam logic [15:0] DebLast    = 16'(HPD_DEBOUNCE - 1);

    state_e           state_q, state_d;
    logic [W_CTR-1:0] warm_q, warm_d;
    logic [15:0]      deb_q, deb_d;
    logic             hpd_ok_q, hpd_ok_d;
    logic [9:0]       clk_pattern_q;
    logic             lane_en_q, timing_rst_n_q, link_up_q;

    always_comb begin
        deb_d    = '0;
        hpd_ok_d = hpd_ok_q;
        if (hpd != hpd_ok_q) begin
            if (deb_q == DebLast) begin
                hpd_ok_d = ~hpd_ok_q;
            end else begin
                deb_d = deb_q + 16'd1;
            end
        end
    end

    // Loss of HPD uses the next debounced value so lanes stop on the edge hpd_ok falls.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        if (!hpd_ok_d) begin
            state_d = StOff;
        end else begin
            unique case (state_q)
                StOff: begin
                    if (en && hpd_ok_q) begin
                        state_d = StClkOnly;
                        warm_d  = warmup_cycles;
                    end
                end
                StClkOnly: begin
                    if (!en) begin
                        state_d = StOff;
                    end else if (warm_q == '0) begin
                        state_d = StRun;
                    end else begin
                        warm_d = warm_q - W_CTR'(1);
                    end
                end
                StRun: begin
                    if (!en) state_d = StDrain;
                end
                StDrain: begin
                    if (en) begin
                        state_d = StRun;
                    end else if (frame_end) begin
                        state_d = StOff;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_n_pix) begin
            state_q        <= StOff;
            warm_q         <= '0;
            deb_q          <= '0;
            hpd_ok_q       <= 1'b0;
            clk_pattern_q  <= '0;
            lane_en_q      <= 1'b0;
            timing_rst_n_q <= 1'b0;
            link_up_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            warm_q         <= warm_d;
            deb_q          <= deb_d;
            hpd_ok_q       <= hpd_ok_d;
            clk_pattern_q  <= (state_d != StOff) ? ClkPattern : 10'h000;
            lane_en_q      <= (state_d == StRun) || (state_d == StDrain);
            timing_rst_n_q <= (state_d == StRun) || (state_d == StDrain);
            link_up_q      <= (state_d == StRun);
        end
    end

    assign state        = state_q;
    assign hpd_ok       = hpd_ok_q;
    assign clk_pattern  = clk_pattern_q;
    assign lane_en      = lane_en_q;
    assign timing_rst_n = timing_rst_n_q;
    assign link_up      = link_up_q;

endmodule
